// File: rtl/sec_counter.sv
// Seconds stage of a stopwatch: BCD 00..59 count with a run/pause toggle and a minute carry.
// Optional `running` status output is enabled with the macro SEC_RUN_STATUS_EN.
module sec_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       start_stop,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       add_min_l
`ifdef SEC_RUN_STATUS_EN
  ,
  output logic       running
`endif
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             ss_prev;
  logic             run;
  logic [PRE_W-1:0] pre;
  logic             ss_rise;
  logic             pre_wrap;
  logic             tick;
  logic             at_max;

  // Next BCD value; any out-of-range digit folds back into the legal range.
  function automatic logic [7:0] bcd_next(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] r;
    if (l >= 4'd9) begin
      if (h >= 4'd5) r = 8'h00;
      else           r = {h + 4'd1, 4'd0};
    end else begin
      r = {h, l + 4'd1};
    end
    return r;
  endfunction

  assign ss_rise  = start_stop & ~ss_prev;
  assign pre_wrap = (pre == PRE_LAST);
  // A toggle or clear in the same cycle pre-empts counting, so the tick is suppressed.
  assign tick     = run & pre_wrap & ~ss_rise & ~clear;
  assign at_max   = (sec_h == 4'd5) && (sec_l == 4'd9);
  assign add_min_l = tick & at_max & ~rst_n;

`ifdef SEC_RUN_STATUS_EN
  assign running = run;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ss_prev <= 1'b0;
      run     <= 1'b0;
      pre     <= '0;
      sec_h   <= 4'd0;
      sec_l   <= 4'd0;
    end else begin
      ss_prev <= start_stop;
      if (clear) begin
        run   <= 1'b0;
        pre   <= '0;
        sec_h <= 4'd0;
        sec_l <= 4'd0;
      end else if (ss_rise) begin
        run <= ~run;
      end else if (run) begin
        pre <= pre_wrap ? '0 : pre + 1'b1;
        if (pre_wrap) {sec_h, sec_l} <= bcd_next(sec_h, sec_l);
      end
    end
  end

endmodule

// File: tb/tb_sec_counter.sv
// Directed bench for sec_counter at TICK_DIV=1 with hand-computed BCD expectations.
module tb_sec_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       start_stop;
  logic [3:0] sec_h;
  logic [3:0] sec_l;
  logic       add_min_l;
`ifdef SEC_RUN_STATUS_EN
  logic       running;
`endif

  int errors = 0;
  int checks = 0;

  sec_counter #(.TICK_DIV(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .start_stop (start_stop),
    .sec_h      (sec_h),
    .sec_l      (sec_l),
    .add_min_l  (add_min_l)
`ifdef SEC_RUN_STATUS_EN
    ,
    .running    (running)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1ns after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] cnt();
    return {24'h0, sec_h, sec_l};
  endfunction

  initial begin
    rst_n = 1'b1;
    clear = 1'b0;
    start_stop = 1'b0;
    step(10);
    chk("reset_count", cnt(), 32'h00);
    chk("reset_carry", {31'h0, add_min_l}, 32'h0);
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_after_reset", cnt(), 32'h00);
    end
    chk("idle_carry", {31'h0, add_min_l}, 32'h0);
`ifdef SEC_RUN_STATUS_EN
    chk("idle_running", {31'h0, running}, 32'h0);
`endif

    // Counting: pulse then ten ticks
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    chk("start_edge_no_inc", cnt(), 32'h00);
`ifdef SEC_RUN_STATUS_EN
    chk("running_set", {31'h0, running}, 32'h1);
`endif
    step(10);
    chk("count_10", cnt(), 32'h10);

    // Wrap from 00 through 59
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear_before_wrap", cnt(), 32'h00);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    step(58);
    chk("count_58", cnt(), 32'h58);
    chk("carry_at_58", {31'h0, add_min_l}, 32'h0);
    step(1);
    chk("count_59", cnt(), 32'h59);
    chk("carry_at_59", {31'h0, add_min_l}, 32'h1);
    step(1);
    chk("wrap_00", cnt(), 32'h00);
    chk("carry_after_wrap", {31'h0, add_min_l}, 32'h0);
    step(1);
    chk("after_wrap_01", cnt(), 32'h01);

    // Pause at 37, hold, resume
    step(36);
    chk("count_37", cnt(), 32'h37);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    chk("pause_edge", cnt(), 32'h37);
    step(10);
    chk("paused_hold", cnt(), 32'h37);
    chk("paused_carry", {31'h0, add_min_l}, 32'h0);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    chk("resume_edge", cnt(), 32'h37);
    step(1);
    chk("resume_38", cnt(), 32'h38);
    step(1);
    chk("resume_39", cnt(), 32'h39);

    // Clear while running at 25
    step(46);
    chk("count_25", cnt(), 32'h25);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear_00", cnt(), 32'h00);
    step(5);
    chk("clear_paused", cnt(), 32'h00);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    step(3);
    chk("after_clear_03", cnt(), 32'h03);

    // Clear masks the carry at 59
    step(56);
    chk("count_59_b", cnt(), 32'h59);
    chk("carry_59_b", {31'h0, add_min_l}, 32'h1);
    clear = 1'b1;
    #1;
    chk("carry_masked_by_clear", {31'h0, add_min_l}, 32'h0);
    step(1);
    chk("clear_at_59", cnt(), 32'h00);

    // Clear and start edge together: clear wins, edge still recorded
    start_stop = 1'b1;
    step(1);
    clear = 1'b0;
    step(3);
    chk("clear_beats_edge", cnt(), 32'h00);
    start_stop = 1'b0;
    step(1);

    // Held start_stop toggles once
    start_stop = 1'b1;
    step(1);
    chk("held_edge", cnt(), 32'h00);
    step(4);
    chk("held_count_04", cnt(), 32'h04);
    start_stop = 1'b0;
    step(3);
    chk("held_count_07", cnt(), 32'h07);

    // Reset mid-count overrides clear and start_stop
    rst_n = 1'b1;
    clear = 1'b1;
    start_stop = 1'b1;
    step(1);
    chk("mid_reset", cnt(), 32'h00);
    rst_n = 1'b0;
    clear = 1'b0;
    start_stop = 1'b0;
    step(3);
    chk("post_reset_paused", cnt(), 32'h00);
    chk("post_reset_carry", {31'h0, add_min_l}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
